// File: rtl/tcdm_periph_initiator.sv
// Initiator for the single-cycle peripheral bus: turns a valid/ready command
// stream into req/gnt/r_valid transactions and queues responses in order.
module tcdm_periph_initiator #(
  parameter int unsigned ID_WIDTH        = 5,
  parameter int unsigned RSP_DEPTH       = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [31:0]         cmd_addr_i,
  input  logic                cmd_write_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic [3:0]          cmd_be_i,
  output logic                req_o,
  output logic [31:0]         addr_o,
  output logic                wen_o,
  output logic [31:0]         wdata_o,
  output logic [3:0]          be_o,
  output logic [ID_WIDTH-1:0] id_o,
  input  logic                gnt_i,
  input  logic                r_valid_i,
  input  logic                r_opc_i,
  input  logic [ID_WIDTH-1:0] r_id_i,
  input  logic [31:0]         r_rdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [ID_WIDTH-1:0] rsp_id_o,
  input  logic                clear_i,
  output logic                err_timeout_o,
  output logic                err_id_o,
  output logic                busy_o
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [31:0]         rdata;
    logic [ID_WIDTH-1:0] id;
    logic                err;
  } rsp_t;

  logic                hold_valid;
  logic [CW-1:0]       outstanding, fifo_count;
  logic [ID_WIDTH-1:0] issue_id, expect_id;
  logic [TW-1:0]       tmo_cnt;
  rsp_t                mem [RSP_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;

  logic credit_ok, grant, cmd_acc, rsp_acc, stray, id_bad, tmo_hit, push, pop;

  // Credit covers both in-flight and queued responses so a push always has room.
  assign credit_ok = (outstanding < CW'(MAX_OUTSTANDING)) &&
                     ((outstanding + fifo_count) < CW'(RSP_DEPTH));
  assign req_o       = hold_valid & credit_ok;
  assign grant       = req_o & gnt_i;
  assign cmd_ready_o = ~rst_i & (~hold_valid | grant);
  assign cmd_acc     = cmd_valid_i & cmd_ready_o;
  assign id_o        = issue_id;

  assign rsp_acc = r_valid_i & (outstanding != '0);
  assign stray   = r_valid_i & (outstanding == '0);
  assign id_bad  = (r_id_i != expect_id);
  assign tmo_hit = (outstanding != '0) & ~r_valid_i & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign push        = rsp_acc;
  assign rsp_valid_o = (fifo_count != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = mem[rd_ptr].rdata;
  assign rsp_id_o    = mem[rd_ptr].id;
  assign rsp_err_o   = mem[rd_ptr].err;
  assign busy_o      = hold_valid | (outstanding != '0) | rsp_valid_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      addr_o     <= '0;
      wen_o      <= 1'b0;
      wdata_o    <= '0;
      be_o       <= '0;
    end else if (cmd_acc) begin
      hold_valid <= 1'b1;
      addr_o     <= cmd_addr_i;
      wen_o      <= ~cmd_write_i;
      wdata_o    <= cmd_wdata_i;
      be_o       <= cmd_be_i;
    end else if (grant) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_id      <= '0;
      expect_id     <= '0;
      outstanding   <= '0;
      tmo_cnt       <= '0;
      err_timeout_o <= 1'b0;
      err_id_o      <= 1'b0;
    end else begin
      if (grant) issue_id <= issue_id + 1'b1;

      // Timed-out transactions are abandoned; resync the expected id so the
      // next granted transaction is checked against its own id.
      if (tmo_hit) begin
        outstanding <= grant ? CW'(1) : '0;
        expect_id   <= issue_id;
      end else begin
        if (grant && !rsp_acc)      outstanding <= outstanding + 1'b1;
        else if (!grant && rsp_acc) outstanding <= outstanding - 1'b1;
        if (rsp_acc) expect_id <= expect_id + 1'b1;
      end

      if (outstanding == '0 || r_valid_i || tmo_hit) tmo_cnt <= '0;
      else                                           tmo_cnt <= tmo_cnt + 1'b1;

      err_timeout_o <= tmo_hit | (err_timeout_o & ~clear_i);
      err_id_o      <= (rsp_acc & id_bad) | stray | (err_id_o & ~clear_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{rdata: r_rdata_i, id: r_id_i, err: r_opc_i | id_bad};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_periph_initiator.sv
// Bench for tcdm_periph_initiator: command table plus scoreboarded bus slave
// model, with hand sequences for stall, backpressure, id errors and timeout.
module tb_tcdm_periph_initiator;
  localparam int IDW  = 5;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam int TMO  = 16;

  logic clk_i = 1'b0, rst_i;
  logic cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  logic req_o, wen_o, gnt_i, r_valid_i, r_opc_i, rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] addr_o, wdata_o, r_rdata_i, rsp_rdata_o;
  logic [3:0]  be_o;
  logic [IDW-1:0] id_o, r_id_i, rsp_id_o;
  logic clear_i, err_timeout_o, err_id_o, busy_o;

  tcdm_periph_initiator #(.ID_WIDTH(IDW), .RSP_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO),
                          .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_write_i(cmd_write_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .req_o(req_o), .addr_o(addr_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
    .id_o(id_o), .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_opc_i(r_opc_i),
    .r_id_i(r_id_i), .r_rdata_i(r_rdata_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_id_o(rsp_id_o), .clear_i(clear_i), .err_timeout_o(err_timeout_o),
    .err_id_o(err_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {logic [31:0] rdata; logic [IDW-1:0] id; logic err;} rsp_exp_t;
  typedef struct {logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] be; logic [IDW-1:0] id;} bus_exp_t;
  typedef struct {logic [31:0] data; logic [IDW-1:0] id;} pend_t;
  typedef struct {logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic exp_wen;} vec_t;

  rsp_exp_t sb_q[$];
  bus_exp_t bus_q[$];
  pend_t    pend_q[$];

  int n_cmp = 0, n_bad = 0;
  int n_gnt = 0, run = 0, max_run = 0, gnt_cyc = 0;
  logic [IDW-1:0] exp_id = '0, id_xor = '0;
  bit resp_en = 1, stray_req = 0, no_sb = 0, bp_done = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // Bus monitor, response scoreboard and slave model share one process so
  // checks always see the values of the cycle before the slave updates.
  always @(negedge clk_i) begin
    if (rst_i) begin
      pend_q.delete();
      r_valid_i = 1'b0;
      run = 0;
    end else begin
      if (req_o) begin
        run++;
        if (run > max_run) max_run = run;
        if (bus_q.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          chk("bus_addr", addr_o, bus_q[0].addr);
          chk("bus_wen", wen_o, bus_q[0].wen);
          chk("bus_wdata", wdata_o, bus_q[0].wdata);
          chk("bus_be", be_o, bus_q[0].be);
          chk("bus_id", id_o, bus_q[0].id);
        end
      end else run = 0;
      if (req_o && gnt_i) begin
        if (bus_q.size() != 0) void'(bus_q.pop_front());
        n_gnt++;
        gnt_cyc = cyc + 1;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          rsp_exp_t e;
          e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_id", rsp_id_o, e.id);
          chk("rsp_err", rsp_err_o, e.err);
        end
      end
      // Slave answers one cycle after grant; read data is the latched wdata.
      if (resp_en && pend_q.size() != 0) begin
        pend_t p;
        p = pend_q.pop_front();
        r_valid_i = 1'b1; r_id_i = p.id ^ id_xor; r_rdata_i = p.data;
      end else if (stray_req) begin
        r_valid_i = 1'b1; r_id_i = '0; r_rdata_i = 32'hDEAD_BEEF;
      end else r_valid_i = 1'b0;
      if (req_o && gnt_i) pend_q.push_back('{wdata_o, id_o});
    end
  end

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic wen_exp);
    int t = 0;
    bit ok = 0;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_wdata_i = d; cmd_be_i = b;
    while (!ok && t < 200) begin
      @(negedge clk_i);
      if (cmd_ready_o) ok = 1;
      t++;
    end
    if (!ok) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    bus_q.push_back('{a, wen_exp, d, b, exp_id});
    if (!no_sb) sb_q.push_back('{d, exp_id ^ id_xor, id_xor != '0});
    exp_id++;
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || bus_q.size() != 0 || pend_q.size() != 0 || busy_o) && t < 300) begin
      @(posedge clk_i); #1;
      t++;
    end
    chk("drain_done", t < 300, 1);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1 rst_i = 1'b1;
    sb_q.delete(); bus_q.delete(); exp_id = '0; id_xor = '0;
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 32'h1A10_B000, 32'hCAFE_0001, 4'hF, 1'b0};
    tbl[1] = '{1'b0, 32'h1A10_B004, 32'h0000_1234, 4'hF, 1'b1};
    tbl[2] = '{1'b1, 32'h1A10_B00C, 32'hFFFF_FFFF, 4'h3, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h1, 1'b1};
    tbl[4] = '{1'b1, 32'hFFFF_FFFC, 32'h8000_0000, 4'hC, 1'b0};
    tbl[5] = '{1'b0, 32'h1A10_B100, 32'hA5A5_5A5A, 4'h0, 1'b1};

    rst_i = 1'b1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_wdata_i = '0;
    cmd_be_i = '0; gnt_i = 1'b1; rsp_ready_i = 1'b1; clear_i = 1'b0; r_opc_i = 1'b0;
    r_valid_i = 1'b0; r_id_i = '0; r_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", req_o, 0);
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_wen", wen_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_id", id_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_errs", {err_timeout_o, err_id_o}, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Single read: response appears three sampling points after accept.
    begin
      int lat = 0;
      send(1'b0, 32'h1A10_B008, 32'h0000_002A, 4'hF, 1'b1);
      while (!rsp_valid_o && lat < 50) begin @(negedge clk_i); lat++; end
      chk("rd_latency", lat, 3);
    end
    drain();

    for (int i = 0; i < 6; i++) send(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp_wen);
    drain();

    // Back-to-back writes, ids 0..3.
    do_reset();
    max_run = 0;
    for (int i = 0; i < 4; i++) send(1'b1, 32'h1A10_C000 + 32'(i * 4), 32'h5000 + 32'(i), 4'hF, 1'b0);
    drain();
    chk("b2b_req_run", max_run, 4);

    // Stalled grant.
    gnt_i = 1'b0;
    send(1'b1, 32'h1A10_D000, 32'h1111_2222, 4'h6, 1'b0);
    fork
      send(1'b1, 32'h1A10_D004, 32'h3333_4444, 4'h9, 1'b0);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_i);
          chk("stall_ready", cmd_ready_o, 0);
          chk("stall_req", req_o, 1);
        end
        @(posedge clk_i); #1 gnt_i = 1'b1;
      end
    join
    drain();

    // Backpressure: FIFO holds four, one pop lets one more through.
    rsp_ready_i = 1'b0; n_gnt = 0; bp_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 32'h1A10_2000 + 32'(i * 4), 32'h100 + 32'(i), 4'hF, 1'b1);
        bp_done = 1;
      end
    join_none
    repeat (20) @(posedge clk_i);
    #1;
    chk("bp_grants", n_gnt, 4);
    chk("bp_req_low", req_o, 0);
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1 rsp_ready_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    chk("bp_grants_after_pop", n_gnt, 5);
    rsp_ready_i = 1'b1;
    begin
      int t = 0;
      while (!bp_done && t < 200) begin @(posedge clk_i); #1; t++; end
      chk("bp_sends_done", bp_done, 1);
    end
    drain();

    // Id mismatch, stray response, clear and clear-vs-event priority.
    do_reset();
    id_xor = 5'd3;
    send(1'b0, 32'h1A10_E000, 32'h0000_0055, 4'hF, 1'b1);
    drain();
    id_xor = '0;
    chk("idmis_err_id", err_id_o, 1);
    clear_i = 1'b1; @(posedge clk_i); #1 clear_i = 1'b0;
    chk("clear_err_id", err_id_o, 0);
    stray_req = 1'b1; @(posedge clk_i); #1 stray_req = 1'b0;
    @(posedge clk_i); #1;
    chk("stray_err_id", err_id_o, 1);
    chk("stray_no_push", rsp_valid_o, 0);
    clear_i = 1'b1; stray_req = 1'b1; @(posedge clk_i); #1 clear_i = 1'b0; stray_req = 1'b0;
    chk("clear_vs_err", err_id_o, 1);
    clear_i = 1'b1; @(posedge clk_i); #1 clear_i = 1'b0;
    chk("clear_again", err_id_o, 0);

    // Timeout: unanswered read, then its late response is stray.
    do_reset();
    resp_en = 0; no_sb = 1;
    send(1'b0, 32'h1A10_B010, 32'h0000_0077, 4'hF, 1'b1);
    begin
      int w = 0;
      while (!err_timeout_o && w < 100) begin @(negedge clk_i); w++; end
      chk("tmo_seen", err_timeout_o, 1);
      chk("tmo_delay", cyc - gnt_cyc, TMO);
    end
    @(posedge clk_i); #1;
    chk("tmo_busy", busy_o, 0);
    chk("tmo_sticky", err_timeout_o, 1);
    clear_i = 1'b1; @(posedge clk_i); #1 clear_i = 1'b0;
    chk("tmo_clear", err_timeout_o, 0);
    resp_en = 1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("late_rsp_stray", err_id_o, 1);
    chk("late_rsp_no_push", rsp_valid_o, 0);
    no_sb = 0;

    // Reset asserted mid-request drops req_o immediately.
    gnt_i = 1'b0;
    send(1'b1, 32'h1A10_F000, 32'h0BAD_F00D, 4'hF, 1'b0);
    @(posedge clk_i); #1;
    chk("midrst_req_before", req_o, 1);
    rst_i = 1'b1;
    #1;
    chk("midrst_req", req_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_errs", {err_timeout_o, err_id_o}, 0);
    sb_q.delete(); bus_q.delete(); exp_id = '0;
    @(posedge clk_i); #1 rst_i = 1'b0; gnt_i = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
